// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and defaults for the counter_seq_ctrl block.
package counter_seq_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/up_counter.sv
// Loadable free-running up counter; holding a value is done by loading it back.
module up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: load data or wrap-around increment.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data;
    end else begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Two-requester arbitrated counting sequencer (IDLE/LOAD/RUN/DONE).
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             done_id
);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             win_valid_s;
  logic             win_idx_s;
  logic             cnt_load_s;
  logic [WIDTH-1:0] cnt_data_s;
`ifdef ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  // Arbitration: pick the winning requester among asserted req bits.
  always_comb begin
    win_valid_s = |req;
    win_idx_s   = 1'b0;
`ifdef ROUND_ROBIN_EN
    if (req == 2'b11) begin
      win_idx_s = ~last_q;
    end else if (req[1]) begin
      win_idx_s = 1'b1;
    end else begin
      win_idx_s = 1'b0;
    end
`else
    if (req[0]) begin
      win_idx_s = 1'b0;
    end else if (req[1]) begin
      win_idx_s = 1'b1;
    end else begin
      win_idx_s = 1'b0;
    end
`endif
  end

  // Next-state, grant and counter control; the counter holds by reloading itself.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    start_d    = start_q;
    limit_d    = limit_q;
    cnt_load_s = 1'b1;
    cnt_data_s = count;
`ifdef ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d = LOAD;
          gnt_d   = win_idx_s ? 2'b10 : 2'b01;
          start_d = win_idx_s ? start1 : start0;
          limit_d = win_idx_s ? limit1 : limit0;
`ifdef ROUND_ROBIN_EN
          last_d  = win_idx_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else begin
          cnt_data_s = start_q;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (count == limit_q) begin
          state_d = DONE;
        end else begin
          cnt_load_s = 1'b0;
          state_d    = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == RUN) && (state_d == DONE);
    done_id_d = done_d ? gnt_q[1] : 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      start_q   <= {WIDTH{1'b0}};
      limit_q   <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      start_q   <= start_d;
      limit_q   <= limit_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Last-granted requester; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  up_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load_s),
    .data  (cnt_data_s),
    .count (count)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl (WIDTH = 8).
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] start0, start1, limit0, limit1;
  logic       abort;
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] count;
  logic       done;
  logic       done_id;

  int n_assert;
  int n_fail;

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .start0  (start0),
    .start1  (start1),
    .limit0  (limit0),
    .limit1  (limit1),
    .abort   (abort),
    .gnt     (gnt),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst    = 1'b0;
    req    = 2'b00;
    start0 = 8'd0;
    start1 = 8'd0;
    limit0 = 8'd0;
    limit1 = 8'd0;
    abort  = 1'b0;
    #3;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic run on requester 0: 10..20; start0 changed after sampling must not matter.
    req = 2'b01; start0 = 8'd10; limit0 = 8'd20;
    step();
    chk("r0_gnt", 32'(gnt), 32'd1);
    chk("r0_busy", 32'(busy), 32'd1);
    req = 2'b00; start0 = 8'd99; limit0 = 8'd15;
    step();
    for (int i = 0; i < 11; i++) begin
      chk("r0_count", 32'(count), 32'(10 + i));
      chk("r0_nodone", 32'(done), 32'd0);
      step();
    end
    chk("r0_done", 32'(done), 32'd1);
    chk("r0_done_id", 32'(done_id), 32'd0);
    chk("r0_done_count", 32'(count), 32'd20);
    step();
    chk("r0_done_pulse", 32'(done), 32'd0);
    chk("r0_busy_after", 32'(busy), 32'd0);
    chk("r0_gnt_after", 32'(gnt), 32'd0);
    chk("r0_count_hold", 32'(count), 32'd20);

    // Wrapping run on requester 1: 250..255, 0..3.
    req = 2'b10; start1 = 8'd250; limit1 = 8'd3;
    step();
    chk("r1_gnt", 32'(gnt), 32'd2);
    req = 2'b00;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("r1_count", 32'(count), 32'((250 + i) % 256));
      step();
    end
    chk("r1_done", 32'(done), 32'd1);
    chk("r1_done_id", 32'(done_id), 32'd1);
    step();
    chk("r1_idle", 32'(busy), 32'd0);

    // Both requesting across two runs; an IDLE cycle separates the grants.
    req = 2'b11; start0 = 8'd5; limit0 = 8'd5; start1 = 8'd5; limit1 = 8'd5;
    step();
    chk("both_gnt1", 32'(gnt), 32'd1);
    step();
    chk("both_count1", 32'(count), 32'd5);
    step();
    chk("both_done1", 32'(done), 32'd1);
    chk("both_done_id1", 32'(done_id), 32'd0);
    step();
    chk("both_idle_gnt", 32'(gnt), 32'd0);
    chk("both_idle_busy", 32'(busy), 32'd0);
    step();
`ifdef ROUND_ROBIN_EN
    chk("both_gnt2", 32'(gnt), 32'd2);
`else
    chk("both_gnt2", 32'(gnt), 32'd1);
`endif
    req = 2'b00;
    step();
    step();
    chk("both_done2", 32'(done), 32'd1);
`ifdef ROUND_ROBIN_EN
    chk("both_done_id2", 32'(done_id), 32'd1);
`else
    chk("both_done_id2", 32'(done_id), 32'd0);
`endif
    step();

    // Abort at count 40.
    req = 2'b01; start0 = 8'd0; limit0 = 8'd100;
    step();
    chk("ab_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    step();
    for (int i = 0; i < 40; i++) step();
    chk("ab_count40", 32'(count), 32'd40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_gnt_clr", 32'(gnt), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_count_hold", 32'(count), 32'd40);
    chk("ab_nodone", 32'(done), 32'd0);
    step();
    chk("ab_nodone2", 32'(done), 32'd0);
    chk("ab_count_hold2", 32'(count), 32'd40);

    // Reset in the middle of a run.
    req = 2'b01; start0 = 8'd0; limit0 = 8'd50;
    step();
    req = 2'b00;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("mr_count7", 32'(count), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_done_id", 32'(done_id), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mr_after_done", 32'(done), 32'd0);
      chk("mr_after_busy", 32'(busy), 32'd0);
    end

    // start == limit: exactly one RUN cycle.
    req = 2'b01; start0 = 8'd9; limit0 = 8'd9;
    step();
    req = 2'b00;
    step();
    chk("eq_count", 32'(count), 32'd9);
    chk("eq_nodone", 32'(done), 32'd0);
    chk("eq_busy", 32'(busy), 32'd1);
    step();
    chk("eq_done", 32'(done), 32'd1);
    chk("eq_done_count", 32'(count), 32'd9);
    step();
    chk("eq_done_pulse", 32'(done), 32'd0);
    chk("eq_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
